// File: rtl/sprite_line_render.sv
// Sprite line renderer: walks the per-line sprite list, fetches each visible
// sprite's row from sprite memory and writes opaque pixels to the line buffer.
module sprite_line_render #(
  parameter int unsigned MAX_OBJ_PER_LINE = 32,
  parameter int unsigned LINE_WIDTH       = 640,
  parameter int unsigned SPRITE_SIZE      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9:0]                       sy,
  input  logic [MAX_OBJ_PER_LINE-1:0][8:0] buffer_array,
  input  logic                             line_ready,
  output logic [7:0]                       oam_addr,
  input  logic [31:0]                      oam_data,
  output logic [15:0]                      spr_addr,
  input  logic [3:0]                       spr_data,
  output logic                             lb_we,
  output logic [9:0]                       lb_addr,
  output logic [4:0]                       lb_data,
  output logic                             line_done
);

  localparam int unsigned IW = $clog2(MAX_OBJ_PER_LINE + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PIX, FLUSH, DONE} state_t;

  state_t          state, state_next;
  logic [9:0]      last_sy;
  logic            sy_change;
  logic [IW-1:0]   index;
  logic [8:0]      entry;
  logic [9:0]      row_full;
  logic            skip;
  logic [7:0]      spr_ref;
  logic [3:0]      row;
  logic [3:0]      col;
  logic [3:0]      col_mem;
  logic [9:0]      xpos;
  logic            xflip;
  logic            prio;
  logic [10:0]     pix_sum;
  logic            pix_d;
  logic            in_range_d;
  logic            prio_d;
  logic [9:0]      addr_d;

  assign sy_change = (sy != last_sy);
  assign row_full  = sy - oam_data[27:18];
  assign skip      = !oam_data[31] || (row_full >= 10'(SPRITE_SIZE));
  assign col_mem   = xflip ? ~col : col;
  assign pix_sum   = {1'b0, xpos} + {7'b0, col};

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < MAX_OBJ_PER_LINE; i++) begin
      if (index == IW'(i)) entry = buffer_array[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (line_ready) state_next = FETCH;
      FETCH:   if (index == IW'(MAX_OBJ_PER_LINE) || !entry[0]) state_next = DONE;
               else state_next = WAIT;
      WAIT:    state_next = skip ? FETCH : PIX;
      PIX:     if (col == 4'd15) state_next = FLUSH;
      FLUSH:   state_next = FETCH;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (sy_change) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sy    <= sy;
      index      <= '0;
      spr_ref    <= '0;
      row        <= '0;
      col        <= '0;
      xpos       <= '0;
      xflip      <= 1'b0;
      prio       <= 1'b0;
      pix_d      <= 1'b0;
      in_range_d <= 1'b0;
      prio_d     <= 1'b0;
      addr_d     <= '0;
    end else begin
      last_sy    <= sy;
      // Pixel stage lines up with spr_data returning one cycle after spr_addr.
      pix_d      <= (state == PIX) && !sy_change;
      in_range_d <= (pix_sum < 11'(LINE_WIDTH));
      prio_d     <= prio;
      if (state == PIX) addr_d <= pix_sum[9:0];
      if (sy_change) begin
        index <= '0;
      end else begin
        case (state)
          WAIT: begin
            spr_ref <= oam_data[7:0];
            xpos    <= oam_data[17:8];
            xflip   <= oam_data[29];
            prio    <= oam_data[28];
            row     <= oam_data[30] ? ~row_full[3:0] : row_full[3:0];
            col     <= '0;
            if (skip) index <= index + IW'(1);
          end
          PIX:     col   <= col + 4'd1;
          FLUSH:   index <= index + IW'(1);
          default: ;
        endcase
      end
    end
  end

  assign oam_addr  = (state == FETCH) ? entry[8:1] : '0;
  assign spr_addr  = (state == PIX) ? {spr_ref, row, col_mem} : '0;
  assign lb_we     = pix_d && in_range_d && (spr_data != 4'd0);
  assign lb_addr   = addr_d;
  assign lb_data   = pix_d ? {prio_d, spr_data} : '0;
  assign line_done = (state == DONE);

endmodule
